// File: rtl/obstacle_link_rx.sv
// Game-side receiver for the obstacle chip pin bus: walks the select line over
// both obstacles, double-samples the synchronised bus and publishes both atomically.
module obstacle_link_rx #(
  parameter int SETTLE_CYCLES = 3,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [7:0] link_data_in,
  input  logic [7:0] link_hi_in,
  output logic       link_sel_out,
  output logic [8:0] obstacle1_pos,
  output logic [2:0] obstacle1_type,
  output logic [8:0] obstacle2_pos,
  output logic [2:0] obstacle2_type,
  output logic       update_valid,
  output logic       link_error,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETTLE   = 3'd1;
  localparam logic [2:0] ST_SAMPLE_A = 3'd2;
  localparam logic [2:0] ST_SAMPLE_B = 3'd3;
  localparam logic [2:0] ST_COMMIT   = 3'd4;

  localparam logic [3:0] L_SETTLE = 4'(SETTLE_CYCLES);
  localparam logic [2:0] L_RETRY  = 3'(MAX_RETRIES);

  // Handshake: frame_start is a one-cycle request taken only in IDLE; busy rises on
  // the accepting edge and falls on the COMMIT or fail edge; requests seen while
  // busy (including that final edge) are dropped, never queued.

  logic [2:0]  r_state;
  logic        r_idx;
  logic [3:0]  r_cnt;
  logic [2:0]  r_retry;
  logic [15:0] r_sync1;
  logic [15:0] r_sync2;
  logic [15:0] r_cap;
  logic [11:0] r_shadow1;
  logic [11:0] r_shadow2;
  logic        r_sel;
  logic [8:0]  r_obs1_pos;
  logic [2:0]  r_obs1_type;
  logic [8:0]  r_obs2_pos;
  logic [2:0]  r_obs2_type;
  logic        r_update;
  logic        r_err;
  logic        r_busy;

  logic [15:0] w_s;
  logic        w_match;
  logic        w_marker_ok;
  logic        w_fail;

  assign w_s         = r_sync2;
  assign w_match     = (w_s == r_cap);
  assign w_marker_ok = (w_s[15:12] == 4'hF);

  // A torn pair may be retried; a stable pair without the marker means no device.
  always_comb begin
    w_fail = 1'b0;
    if (r_state == ST_SAMPLE_B) begin
      w_fail = w_match ? !w_marker_ok : (r_retry >= L_RETRY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= 1'b0;
      r_cnt       <= 4'd0;
      r_retry     <= 3'd0;
      r_sync1     <= 16'd0;
      r_sync2     <= 16'd0;
      r_cap       <= 16'd0;
      r_shadow1   <= 12'd0;
      r_shadow2   <= 12'd0;
      r_sel       <= 1'b1;
      r_obs1_pos  <= 9'd0;
      r_obs1_type <= 3'd0;
      r_obs2_pos  <= 9'd0;
      r_obs2_type <= 3'd0;
      r_update    <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sync1  <= {link_hi_in, link_data_in};
      r_sync2  <= r_sync1;
      r_update <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_idx   <= 1'b0;
            r_cnt   <= L_SETTLE;
            r_retry <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= ST_SAMPLE_A;
        end
        ST_SAMPLE_A: begin
          r_cap   <= w_s;
          r_state <= ST_SAMPLE_B;
        end
        ST_SAMPLE_B: begin
          if (w_fail) begin
            r_err   <= 1'b1;
            r_sel   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (!w_match) begin
            r_retry <= r_retry + 3'd1;
            r_state <= ST_SAMPLE_A;
          end else begin
            r_retry <= 3'd0;
            if (!r_idx) begin
              r_shadow1 <= w_s[11:0];
              r_sel     <= 1'b0;
              r_idx     <= 1'b1;
              r_cnt     <= L_SETTLE;
              r_state   <= ST_SETTLE;
            end else begin
              r_shadow2 <= w_s[11:0];
              r_state   <= ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          r_obs1_pos  <= r_shadow1[8:0];
          r_obs1_type <= r_shadow1[11:9];
          r_obs2_pos  <= r_shadow2[8:0];
          r_obs2_type <= r_shadow2[11:9];
          r_update    <= 1'b1;
          r_err       <= 1'b0;
          r_sel       <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign link_sel_out   = r_sel;
  assign obstacle1_pos  = r_obs1_pos;
  assign obstacle1_type = r_obs1_type;
  assign obstacle2_pos  = r_obs2_pos;
  assign obstacle2_type = r_obs2_type;
  assign update_valid   = r_update;
  assign link_error     = r_err;
  assign busy           = r_busy;
  assign dbg_state      = r_state;

endmodule

// File: doc/obstacle_link_rx.md
Name: obstacle_link_rx

Overview:
- Game-side receiver for the obstacle generator chip's pin interface.
- The obstacle chip presents one obstacle at a time on a 16-pin bus:
  - data pins [7:0] carry pos[7:0]
  - hi pins [0] carry pos[8]
  - hi pins [3:1] carry type
  - hi pins [7:4] are a constant 4'hF presence marker
- The selection of which obstacle is presented comes from a select line this block drives: 1 selects obstacle1, 0 selects obstacle2.
- Once per frame this block:
  - walks the select line through both obstacles
  - synchronises and double-samples the bus
  - publishes both obstacles atomically to the game/render logic.

Parameters:
- SETTLE_CYCLES, 3, cycles waited after a select change before sampling. Legal range 2..15; covers pad delay plus the 2-flop synchroniser.
- MAX_RETRIES, 3, extra sample pairs allowed per obstacle after a mismatch before the frame fails. Legal range 0..7.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle request to fetch both obstacles; ignored while busy
- link_data_in  in  8  remote pos[7:0]; asynchronous to clk
- link_hi_in  in  8  remote {marker[3:0], type[2:0], pos[8]}; asynchronous to clk
- link_sel_out  out  1  remote select (1 = obstacle1, 0 = obstacle2)
- obstacle1_pos  out  9  published obstacle1 x-position
- obstacle1_type  out  3  published obstacle1 type
- obstacle2_pos  out  9  published obstacle2 x-position
- obstacle2_type  out  3  published obstacle2 type
- update_valid  out  1  one-cycle pulse when all four published outputs change together
- link_error  out  1  level; set by a failed frame, cleared by the next successful commit
- busy  out  1  high from the frame_start acceptance edge until return to IDLE

Behaviour:
- Reset (async assert, sync release) values:
  - link_sel_out = 1
  - all pos/type outputs = 0
  - update_valid = 0, link_error = 0, busy = 0
  - FSM in IDLE; shadow, capture and retry registers cleared.
- Synchroniser: the 16-bit word s = {link_hi_in, link_data_in} passes through 2 flops. All FSM decisions use only s.
- FSM states: IDLE, SETTLE, SAMPLE_A, SAMPLE_B, COMMIT. Internal idx selects obstacle 1 or 2.
- IDLE:
  - link_sel_out = 1.
  - frame_start = 1 → idx = 1, cnt = SETTLE_CYCLES, retry = 0, busy = 1, go to SETTLE.
- SETTLE: cnt decrements each edge. The edge where cnt == 1 moves to SAMPLE_A, so SETTLE lasts exactly SETTLE_CYCLES edges.
- SAMPLE_A: cap <= s, then go to SAMPLE_B.
- SAMPLE_B, with s == cap and s[15:12] == 4'hF (good sample):
  - shadow[idx] <= {type = s[11:9], pos = s[8:0]}, retry = 0.
  - If idx == 1: link_sel_out <= 0, idx = 2, cnt = SETTLE_CYCLES, go to SETTLE.
  - If idx == 2: go to COMMIT.
- SAMPLE_B, with s != cap (tear or glitch):
  - If retry < MAX_RETRIES: retry++, go to SAMPLE_A without re-settling.
  - Otherwise the frame fails.
- SAMPLE_B, with s == cap but marker != 4'hF (no device): the frame fails immediately; no retry.
- Frame fail:
  - link_error <= 1, link_sel_out <= 1, busy <= 0, go to IDLE.
  - Published outputs keep their previous values; no update_valid.
- COMMIT:
  - All four outputs load from the shadows on the same edge; update_valid = 1 for exactly one cycle.
  - link_error <= 0, link_sel_out <= 1, busy <= 0, go to IDLE.
- Latency with a clean bus: update_valid is high in the cycle following edge 2*SETTLE_CYCLES + 5, counted from the edge that samples frame_start. With the default this is edge 11.
- Each retry adds 2 cycles.
- frame_start while busy: dropped, not queued. frame_start in the same cycle as COMMIT or fail is also dropped.
- Reset mid-frame: abort immediately to reset values; no partial update is ever published.
- Outputs never change except on a COMMIT edge or reset.

Test Plan:
- Clean frame:
  - Stimulus: remote model serves obstacle1 = {pos 250, type 3} when sel = 1 and obstacle2 = {pos 17, type 5} when sel = 0, marker 4'hF; pulse frame_start.
  - Required: update_valid at edge 11; outputs 250/3/17/5; link_sel_out goes 1→0 at edge 5 and back to 1 at edge 11; link_error = 0.
- Tear with retry:
  - Stimulus: obstacle2 pos changes 17→18 between SAMPLE_A and SAMPLE_B, then holds.
  - Required: one retry; update_valid at edge 13; obstacle2_pos = 18.
- Retry exhaustion:
  - Stimulus: obstacle1 bus toggles every cycle.
  - Required: after 1 + MAX_RETRIES = 4 sample pairs, link_error = 1, busy = 0, no update_valid, outputs unchanged from the previous frame. A following clean frame clears link_error and updates the outputs.
- No device:
  - Stimulus: link_hi_in[7:4] = 4'h0.
  - Required: fail at the first SAMPLE_B (edge 5); link_error = 1; link_sel_out = 1; outputs unchanged.
- Busy and reset:
  - Stimulus: frame_start pulsed at edges 3 and 11 of a running frame; then a new frame with rst_n asserted at edge 7.
  - Required: the extra pulses produce no second frame. The reset forces every output to its reset value immediately; the next frame_start after release completes normally.
